// File: rtl/ref_window_buffer.sv
// Circular row store for the motion-estimation search window; optional overflow flag via REF_BUF_OVF_EN.
// Latency: push -> count/buffer_ready 1 cycle; rd_en -> rd_valid/rd_data 1 cycle, one read per cycle.
// Backpressure: in_ready low when full unless adv frees a slot the same cycle; flush drops pushes.
module ref_window_buffer #(
   parameter int PIX_W = 8,
   parameter int WIN_W = 23,
   parameter int WIN_H = 8,
   localparam int DW = PIX_W * WIN_W,
   localparam int AW = $clog2(WIN_H),
   localparam int CW = $clog2(WIN_H + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] ref_data,
   output logic          in_ready,
   input  logic          adv,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_row,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          buffer_ready,
   output logic [CW-1:0] count
`ifdef REF_BUF_OVF_EN
   ,
   output logic          ovf_err
`endif
);

   localparam logic [CW-1:0] FULL = CW'(WIN_H);
   localparam logic [CW:0]   LIM  = (CW+1)'(WIN_H);

   // (base + off) mod WIN_H; both operands stay below 2*WIN_H so one subtract suffices
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [CW-1:0] off);
      logic [CW:0] sum;
      sum = (CW+1)'(base) + (CW+1)'(off);
      if (sum >= LIM) sum = sum - LIM;
      return AW'(sum);
   endfunction

   logic [DW-1:0] mem_q [WIN_H];
   logic [AW-1:0] head_q, head_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_idx;
   logic          rd_hit;
   logic          push, pop;
   logic          rd_valid_q;
   logic [DW-1:0] rd_data_q;
   logic          buffer_ready_q;

   // Accept/slide decisions and next pointer/occupancy; flush overrides both push and adv
   always_comb begin
      in_ready = (count_q != FULL) || (adv && (count_q != '0));
      push     = in_valid && in_ready && !flush;
      pop      = adv && (count_q != '0) && !flush;
      wr_ptr   = wrap_add(head_q, count_q);
      rd_idx   = wrap_add(head_q, CW'(rd_row));
      rd_hit   = CW'(rd_row) < count_q;
      head_d   = head_q;
      count_d  = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         if (pop) head_d = wrap_add(head_q, CW'(1));
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Row storage, deliberately unreset; with full+adv the write hits the slot being vacated
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= ref_data;
   end

   // Pointer, occupancy and window-ready registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q         <= '0;
         count_q        <= '0;
         buffer_ready_q <= 1'b0;
      end else begin
         head_q         <= head_d;
         count_q        <= count_d;
         buffer_ready_q <= (count_d == FULL);
      end
   end

   // Registered read port, uses pre-update head/count; same-cycle write returns old contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en && rd_hit;
         if (rd_en) rd_data_q <= rd_hit ? mem_q[rd_idx] : '0;
      end
   end

`ifdef REF_BUF_OVF_EN
   logic ovf_q;
   // Sticky overflow: a row offered while no slot is available; cleared by flush or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     ovf_q <= 1'b0;
      else if (flush)                 ovf_q <= 1'b0;
      else if (in_valid && !in_ready) ovf_q <= 1'b1;
   end
   assign ovf_err = ovf_q;
`endif

   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign buffer_ready = buffer_ready_q;
   assign count        = count_q;

endmodule
